// File: rtl/tree_traverse_engine_pkg.sv
// Shared definitions for the decision-tree traversal engine: ROM node field
// layout, leaf marker, FSM state encoding and the IEEE-754 double ordering key.
package tree_traverse_engine_pkg;

   localparam int NODE_ID_MSB = 107;
   localparam int NODE_ID_LSB = 96;
   localparam int FEAT_MSB    = 95;
   localparam int FEAT_LSB    = 92;
   localparam int THR_MSB     = 91;
   localparam int THR_LSB     = 28;
   localparam int LEFT_MSB    = 27;
   localparam int LEFT_LSB    = 16;
   localparam int RIGHT_MSB   = 15;
   localparam int RIGHT_LSB   = 4;
   localparam int CLASS_MSB   = 3;
   localparam int CLASS_LSB   = 0;

   localparam logic [3:0] LEAF_CODE = 4'h3;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_WAIT,
      ST_EVAL,
      ST_DONE
   } state_t;

   // Maps a double onto an unsigned key whose integer order matches the float
   // order (with -0.0 below +0.0).
   function automatic logic [63:0] dbl_key(input logic [63:0] d);
      return d[63] ? ~d : {~d[63], d[62:0]};
   endfunction

endpackage

// File: rtl/tree_traverse_engine_fp64_le_cmp.sv
// Combinational IEEE-754 double "a <= b" using the package ordering key.
module fp64_le_cmp
   import tree_traverse_engine_pkg::*;
(
   input  logic [63:0] a,
   input  logic [63:0] b,
   output logic        le
);

   assign le = (dbl_key(a) <= dbl_key(b));

endmodule

// File: rtl/tree_traverse_engine.sv
// Decision-tree inference engine: walks an external registered-read tree ROM
// from node 0, comparing feature registers against node thresholds.
module tree_traverse_engine
   import tree_traverse_engine_pkg::*;
#(
   parameter int NODE_WIDTH = 120,
   parameter int ADDR_WIDTH = 10,
   parameter int MAX_DEPTH  = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  feat_we,
   input  logic [3:0]            feat_idx,
   input  logic [63:0]           feat_data,
   input  logic                  start,
   output logic                  busy,
   output logic [ADDR_WIDTH-1:0] addr,
   input  logic [NODE_WIDTH-1:0] node_data,
   output logic                  result_valid,
   input  logic                  result_ready,
   output logic [3:0]            result_class,
   output logic                  result_err
);

   localparam int DW = $clog2(MAX_DEPTH + 1);

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DW-1:0]         depth_q, depth_d;
   logic [3:0]            class_q, class_d;
   logic                  err_q, err_d;
   logic [107:0]          node_q;
   logic [63:0]           feat_q [16];

   logic        go_left;
   logic [11:0] child;
   logic        unused_node_hi;

   assign unused_node_hi = ^node_data[NODE_WIDTH-1:108];

   // Write port is independent of the FSM; EVAL reads the pre-edge value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < 16; i++) feat_q[i] <= '0;
      end else if (feat_we) begin
         feat_q[feat_idx] <= feat_data;
      end
   end

   fp64_le_cmp u_cmp (
      .a  (feat_q[node_q[FEAT_MSB:FEAT_LSB]]),
      .b  (node_q[THR_MSB:THR_LSB]),
      .le (go_left)
   );

   assign child = go_left ? node_q[LEFT_MSB:LEFT_LSB] : node_q[RIGHT_MSB:RIGHT_LSB];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         depth_q <= '0;
         class_q <= '0;
         err_q   <= 1'b0;
         node_q  <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         depth_q <= depth_d;
         class_q <= class_d;
         err_q   <= err_d;
         if (state_q == ST_WAIT) node_q <= node_data[107:0];
      end
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      depth_d = depth_q;
      class_d = class_q;
      err_d   = err_q;
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_FETCH;
               addr_d  = '0;
               depth_d = '0;
               class_d = '0;
               err_d   = 1'b0;
            end
         end
         ST_FETCH: state_d = ST_WAIT;
         ST_WAIT:  state_d = ST_EVAL;
         ST_EVAL: begin
            state_d = ST_DONE;
            // Priority: corrupt node, leaf, depth budget, out-of-range child.
            if (node_q[NODE_ID_MSB:NODE_ID_LSB] != 12'(addr_q)) begin
               err_d   = 1'b1;
               class_d = '0;
            end else if (node_q[FEAT_MSB:FEAT_LSB] == LEAF_CODE) begin
               class_d = node_q[CLASS_MSB:CLASS_LSB];
            end else if ((depth_q == DW'(MAX_DEPTH - 1)) || ((child >> ADDR_WIDTH) != '0)) begin
               err_d   = 1'b1;
               class_d = '0;
            end else begin
               state_d = ST_FETCH;
               addr_d  = ADDR_WIDTH'(child);
               depth_d = depth_q + DW'(1);
            end
         end
         ST_DONE: begin
            if (result_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign busy         = (state_q == ST_FETCH) || (state_q == ST_WAIT) || (state_q == ST_EVAL);
   assign result_valid = (state_q == ST_DONE);
   assign addr         = addr_q;
   assign result_class = class_q;
   assign result_err   = err_q;

endmodule

// File: tb/tb_tree_traverse_engine.sv
// Directed bench for tree_traverse_engine with a behavioural registered-read ROM.
module tb_tree_traverse_engine;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         feat_we;
   logic [3:0]   feat_idx;
   logic [63:0]  feat_data;
   logic         start;
   logic         busy;
   logic [9:0]   addr;
   logic [119:0] node_data;
   logic         result_valid;
   logic         result_ready;
   logic [3:0]   result_class;
   logic         result_err;

   logic [119:0] rom [0:1023];

   int total = 0;
   int bad   = 0;

   localparam logic [63:0] THR0 = 64'h43C2154C50000000;

   always #5 clk = ~clk;

   always @(posedge clk) node_data <= rom[addr];

   tree_traverse_engine #(
      .NODE_WIDTH (120),
      .ADDR_WIDTH (10),
      .MAX_DEPTH  (32)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .feat_we      (feat_we),
      .feat_idx     (feat_idx),
      .feat_data    (feat_data),
      .start        (start),
      .busy         (busy),
      .addr         (addr),
      .node_data    (node_data),
      .result_valid (result_valid),
      .result_ready (result_ready),
      .result_class (result_class),
      .result_err   (result_err)
   );

   typedef struct {
      logic [63:0] f;
      logic [63:0] t;
      bit          left;
   } vec_t;

   vec_t vecs [8];

   function automatic logic [119:0] mk(input logic [11:0] id, input logic [3:0] f,
                                       input logic [63:0] t, input logic [11:0] l,
                                       input logic [11:0] r, input logic [3:0] c);
      return {12'h000, id, f, t, l, r, c};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic set_feat(input logic [3:0] idx, input logic [63:0] val);
      @(negedge clk);
      feat_we = 1'b1; feat_idx = idx; feat_data = val;
      @(negedge clk);
      feat_we = 1'b0;
   endtask

   // Pulses start and counts cycles after the start edge until result_valid.
   task automatic run(input int limit, output int cyc, output logic [9:0] a3);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 0;
      a3  = '0;
      while (!result_valid && cyc < limit) begin
         @(negedge clk);
         cyc++;
         if (cyc == 3) a3 = addr;
      end
   endtask

   task automatic ack();
      result_ready = 1'b1;
      @(negedge clk);
      result_ready = 1'b0;
      chk("valid_after_ack", {63'd0, result_valid}, 64'd0);
   endtask

   initial begin
      int          cyc;
      logic [9:0]  a3;
      int          seen;

      rst_n = 1'b0; feat_we = 1'b0; feat_idx = '0; feat_data = '0;
      start = 1'b0; result_ready = 1'b0;
      for (int i = 0; i < 1024; i++) rom[i] = '0;

      vecs[0] = '{64'h0000000000000000, THR0, 1'b1};
      vecs[1] = '{64'h7FF0000000000000, THR0, 1'b0};
      vecs[2] = '{THR0, THR0, 1'b1};
      vecs[3] = '{64'h8000000000000000, 64'h0000000000000000, 1'b1};
      vecs[4] = '{64'h0000000000000000, 64'h8000000000000000, 1'b0};
      vecs[5] = '{64'hBFF0000000000000, 64'hC000000000000000, 1'b0};
      vecs[6] = '{64'hC008000000000000, 64'hC000000000000000, 1'b1};
      vecs[7] = '{64'h3FF0000000000000, 64'h4000000000000000, 1'b1};

      repeat (3) @(negedge clk);
      chk("rst_busy",  {63'd0, busy}, 64'd0);
      chk("rst_addr",  {54'd0, addr}, 64'd0);
      chk("rst_valid", {63'd0, result_valid}, 64'd0);
      chk("rst_class", {60'd0, result_class}, 64'd0);
      chk("rst_err",   {63'd0, result_err}, 64'd0);
      rst_n = 1'b1;

      rom[1] = mk(12'd1, 4'h3, '0, 12'd0, 12'd0, 4'd5);
      rom[2] = mk(12'd2, 4'h3, '0, 12'd0, 12'd0, 4'd9);

      // Feature file cleared by reset: +0.0 > -0.0 goes right.
      rom[0] = mk(12'd0, 4'd10, 64'h8000000000000000, 12'd1, 12'd2, 4'd0);
      run(50, cyc, a3);
      chk("clr_addr",  {54'd0, a3}, 64'd2);
      chk("clr_class", {60'd0, result_class}, 64'd9);
      ack();

      for (int i = 0; i < 8; i++) begin
         set_feat(4'd10, vecs[i].f);
         rom[0] = mk(12'd0, 4'd10, vecs[i].t, 12'd1, 12'd2, 4'd0);
         run(50, cyc, a3);
         chk($sformatf("v%0d_cyc", i), 64'(cyc), 64'd6);
         chk($sformatf("v%0d_addr", i), {54'd0, a3}, vecs[i].left ? 64'd1 : 64'd2);
         chk($sformatf("v%0d_class", i), {60'd0, result_class}, vecs[i].left ? 64'd5 : 64'd9);
         chk($sformatf("v%0d_err", i), {63'd0, result_err}, 64'd0);
         ack();
      end

      // Three-level walk 0 -> 1 -> 4 (leaf, class 1).
      set_feat(4'd10, 64'h0);
      set_feat(4'd2, 64'hBFF0000000000000);
      rom[0] = mk(12'd0, 4'd10, THR0, 12'd1, 12'd2, 4'd0);
      rom[1] = mk(12'd1, 4'd2, 64'h0, 12'd4, 12'd5, 4'd0);
      rom[4] = mk(12'd4, 4'h3, '0, 12'd0, 12'd0, 4'd1);
      rom[5] = mk(12'd5, 4'h3, '0, 12'd0, 12'd0, 4'd7);
      run(50, cyc, a3);
      chk("lvl3_cyc",   64'(cyc), 64'd9);
      chk("lvl3_class", {60'd0, result_class}, 64'd1);
      chk("lvl3_err",   {63'd0, result_err}, 64'd0);
      ack();

      // Self loop exhausts the depth budget.
      rom[0] = mk(12'd0, 4'd10, THR0, 12'd0, 12'd0, 4'd0);
      run(200, cyc, a3);
      chk("loop_cyc",   64'(cyc), 64'd96);
      chk("loop_err",   {63'd0, result_err}, 64'd1);
      chk("loop_class", {60'd0, result_class}, 64'd0);
      ack();

      // Child 6 holds node_id 7.
      rom[0] = mk(12'd0, 4'd10, THR0, 12'd6, 12'd6, 4'd0);
      rom[6] = mk(12'd7, 4'h3, '0, 12'd0, 12'd0, 4'd4);
      run(50, cyc, a3);
      chk("id_cyc",   64'(cyc), 64'd6);
      chk("id_err",   {63'd0, result_err}, 64'd1);
      chk("id_class", {60'd0, result_class}, 64'd0);
      ack();

      // Child address beyond the 10-bit ROM.
      rom[0] = mk(12'd0, 4'd10, THR0, 12'h400, 12'h400, 4'd0);
      run(50, cyc, a3);
      chk("ovf_cyc", 64'(cyc), 64'd3);
      chk("ovf_err", {63'd0, result_err}, 64'd1);
      ack();

      // Back-pressure: outputs hold and start is ignored while DONE.
      rom[0] = mk(12'd0, 4'd10, THR0, 12'd1, 12'd2, 4'd0);
      rom[1] = mk(12'd1, 4'h3, '0, 12'd0, 12'd0, 4'd5);
      run(50, cyc, a3);
      for (int i = 0; i < 5; i++) begin
         start = i[0];
         @(negedge clk);
         chk("hold_valid", {63'd0, result_valid}, 64'd1);
         chk("hold_class", {60'd0, result_class}, 64'd5);
         chk("hold_err",   {63'd0, result_err}, 64'd0);
      end
      start = 1'b1;
      result_ready = 1'b1;
      @(negedge clk);
      result_ready = 1'b0;
      start = 1'b0;
      chk("hs_valid", {63'd0, result_valid}, 64'd0);
      chk("hs_busy",  {63'd0, busy}, 64'd0);
      @(negedge clk);
      chk("hs_idle_busy", {63'd0, busy}, 64'd0);

      // Reset while waiting on node 1's ROM read.
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      chk("pre_rst_addr", {54'd0, addr}, 64'd1);
      chk("pre_rst_busy", {63'd0, busy}, 64'd1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", {63'd0, busy}, 64'd0);
      chk("mid_rst_addr", {54'd0, addr}, 64'd0);
      @(negedge clk);
      chk("mid_rst_valid", {63'd0, result_valid}, 64'd0);
      chk("mid_rst_class", {60'd0, result_class}, 64'd0);
      chk("mid_rst_err",   {63'd0, result_err}, 64'd0);
      rst_n = 1'b1;
      seen = 0;
      repeat (12) begin
         @(negedge clk);
         if (result_valid) seen++;
      end
      chk("post_rst_no_result", 64'(seen), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
